// File: rtl/intc_mmio.sv
// Memory-mapped interrupt controller on the data-memory port: latches sources into PEND,
// masks them, issues a one-cycle inte request and waits for an EOI before requesting again.
module intc_mmio #(
    parameter int NSRC  = 8,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sel,
    input  logic [2:0]      address,
    input  logic            wren,
    input  logic [31:0]     data,
    output logic [31:0]     q,
    input  logic [NSRC-1:0] src,
    output logic            inte
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t           r_state, w_next;
    logic [NSRC-1:0]  r_pend, r_mask, r_edge, r_prev;
    logic [CNT_W-1:0] r_cnt;

    logic             w_wr, w_rd, w_eoi, w_any;
    logic [NSRC-1:0]  w_pm, w_set, w_clr;
    logic [4:0]       w_idx;
    logic [31:0]      w_rdata;
    logic             w_unused_data;

    assign w_wr          = sel & wren;
    assign w_rd          = sel & ~wren;
    assign w_eoi         = w_wr && (address == 3'd3);
    assign w_pm          = r_pend & r_mask;
    assign w_any         = |w_pm;
    assign w_unused_data = &{1'b0, data};

    // Edge-mode bits fire only on a 0->1 transition; level-mode bits fire while high.
    assign w_set = (r_edge & src & ~r_prev) | (~r_edge & src);

    // An EOI index >= NSRC shifts the one-hot out of range and clears nothing.
    always_comb begin
        w_clr = '0;
        if (w_wr && (address == 3'd0))
            w_clr = data[NSRC-1:0];
        if (w_eoi)
            w_clr = w_clr | (NSRC'(1) << data[4:0]);
    end

    always_comb begin
        w_idx = 5'd0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (w_pm[i])
                w_idx = 5'(i);
    end

    always_comb begin
        case (address)
            3'd0:    w_rdata = 32'(r_pend);
            3'd1:    w_rdata = 32'(r_mask);
            3'd2:    w_rdata = 32'(r_edge);
            3'd3:    w_rdata = {w_any, 26'b0, w_idx};
            3'd4:    w_rdata = 32'(r_cnt);
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_REQ;
            S_REQ:   w_next = S_WAIT;
            S_WAIT:  if (w_eoi || !w_any) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        inte = (r_state == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            r_mask <= '0;
            r_edge <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
            q      <= 32'd0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            r_prev <= src;
            if (w_wr && (address == 3'd1))
                r_mask <= data[NSRC-1:0];
            if (w_wr && (address == 3'd2))
                r_edge <= data[NSRC-1:0];
            // A software clear of COUNT takes priority over a same-cycle increment.
            if (w_wr && (address == 3'd4))
                r_cnt <= '0;
            else if ((r_state == S_IDLE) && w_any && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
            if (w_rd)
                q <= w_rdata;
        end
    end
endmodule

// File: tb/tb_intc_mmio.sv
// Bench for intc_mmio: register table, directed interrupt sequences, and random traffic
// checked every cycle against a transaction-level model of the controller.
module tb_intc_mmio;
    localparam int NSRC  = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int M_IDLE = 0, M_REQ = 1, M_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1, sel = 1'b0, wren = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [31:0] data = 32'd0;
    logic [7:0]  src = 8'd0;
    logic [31:0] q;
    logic        inte;

    int n_chk = 0, n_fail = 0;

    intc_mmio #(.NSRC(NSRC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .sel(sel), .address(address), .wren(wren),
        .data(data), .q(q), .src(src), .inte(inte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: one record of architectural state, advanced once per clock.
    typedef struct {
        logic [7:0]  pend, mask, edg, prev;
        int          cnt;
        int          st;
        logic [31:0] q;
    } mdl_t;

    function automatic mdl_t model_next(mdl_t c, logic rst, logic s, logic w,
                                        logic [2:0] a, logic [31:0] d, logic [7:0] sv);
        mdl_t        n;
        logic [7:0]  pm, clr, setv;
        logic [31:0] rd;
        int          idx;
        bit          wr;
        n = c;
        if (rst) begin
            n.pend = 0; n.mask = 0; n.edg = 0; n.prev = 0;
            n.cnt = 0; n.st = M_IDLE; n.q = 0;
            return n;
        end
        wr  = s && w;
        pm  = c.pend & c.mask;
        idx = -1;
        for (int i = 0; i < 8; i++)
            if (pm[i] && idx < 0) idx = i;
        case (a)
            3'd0:    rd = {24'd0, c.pend};
            3'd1:    rd = {24'd0, c.mask};
            3'd2:    rd = {24'd0, c.edg};
            3'd3:    rd = (idx >= 0) ? (32'h8000_0000 | 32'(idx)) : 32'd0;
            3'd4:    rd = 32'(c.cnt);
            default: rd = 32'd0;
        endcase
        clr = 8'd0;
        if (wr && a == 3'd0) clr = d[7:0];
        if (wr && a == 3'd3 && d[4:0] < 5'd8) clr[d[2:0]] = 1'b1;
        for (int i = 0; i < 8; i++)
            setv[i] = c.edg[i] ? (sv[i] && !c.prev[i]) : sv[i];
        n.pend = (c.pend & ~clr) | setv;
        if (wr && a == 3'd1) n.mask = d[7:0];
        if (wr && a == 3'd2) n.edg  = d[7:0];
        if (wr && a == 3'd4) n.cnt = 0;
        else if (c.st == M_IDLE && pm != 0 && c.cnt < CMAX) n.cnt = c.cnt + 1;
        case (c.st)
            M_IDLE:  if (pm != 0) n.st = M_REQ;
            M_REQ:   n.st = M_WAIT;
            default: if ((wr && a == 3'd3) || pm == 0) n.st = M_IDLE;
        endcase
        n.prev = sv;
        if (s && !w) n.q = rd;
        return n;
    endfunction

    mdl_t m;
    bit   m_ok = 1'b0;

    always @(posedge clk) begin
        m <= model_next(m, reset, sel, wren, address, data, src);
        if (reset) m_ok <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_q", q, m.q);
            chk("model_inte", {31'd0, inte}, {31'd0, m.st == M_REQ});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; wren = 1'b1; address = a; data = d;
        cyc();
        sel = 1'b0; wren = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        sel = 1'b1; wren = 1'b0; address = a;
        cyc();
        sel = 1'b0;
        v = q;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    // Caller drives cycle 0; bits[k] is inte in cycle k, bus/src drop to idle after cycle 0.
    task automatic trace(input int n, input logic [7:0] src_after, output logic [7:0] bits);
        bits = 8'd0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bits[k] = inte;
            cyc();
            sel = 1'b0; wren = 1'b0; src = src_after;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[14];
    logic [31:0] v;
    logic [7:0]  b;

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 32'd0,          32'd0};
        tbl[1]  = '{1'b0, 3'd1, 32'd0,          32'd0};
        tbl[2]  = '{1'b1, 3'd1, 32'hFFFF_FF5A,  32'd0};
        tbl[3]  = '{1'b0, 3'd1, 32'd0,          32'h5A};
        tbl[4]  = '{1'b1, 3'd2, 32'h0000_01C3,  32'd0};
        tbl[5]  = '{1'b0, 3'd2, 32'd0,          32'hC3};
        tbl[6]  = '{1'b0, 3'd3, 32'd0,          32'd0};
        tbl[7]  = '{1'b0, 3'd4, 32'd0,          32'd0};
        tbl[8]  = '{1'b1, 3'd6, 32'hFFFF_FFFF,  32'd0};
        tbl[9]  = '{1'b0, 3'd6, 32'd0,          32'd0};
        tbl[10] = '{1'b0, 3'd5, 32'd0,          32'd0};
        tbl[11] = '{1'b0, 3'd7, 32'd0,          32'd0};
        tbl[12] = '{1'b0, 3'd2, 32'd0,          32'hC3};
        tbl[13] = '{1'b0, 3'd1, 32'd0,          32'h5A};

        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdata);
            else begin
                rd(tbl[i].addr, v);
                chk($sformatf("tbl%0d", i), v, tbl[i].exp);
            end
        end

        // Reset with all sources high: q and inte must clear, PEND stays empty once src drops.
        reset = 1'b1; src = 8'hFF;
        cyc();
        @(negedge clk);
        chk("rst_q", q, 32'd0);
        chk("rst_inte", {31'd0, inte}, 32'd0);
        cyc();
        reset = 1'b0; src = 8'h00;
        rd(3'd0, v); chk("rst_pend", v, 32'd0);
        rd(3'd1, v); chk("rst_mask", v, 32'd0);

        // Edge source pulse.
        wr(3'd2, 32'h04); wr(3'd1, 32'h04);
        src = 8'h04;
        trace(6, 8'h00, b);
        chk("edge_inte", {24'd0, b}, 32'h04);
        rd(3'd3, v); chk("edge_claim", v, 32'h8000_0002);
        rd(3'd4, v); chk("edge_count", v, 32'd1);

        // Priority and EOI with level sources.
        do_reset();
        wr(3'd1, 32'h0A);
        src = 8'h0A;
        trace(6, 8'h00, b);
        chk("prio_inte", {24'd0, b}, 32'h04);
        rd(3'd3, v); chk("prio_claim1", v, 32'h8000_0001);
        sel = 1'b1; wren = 1'b1; address = 3'd3; data = 32'd1;
        trace(6, 8'h00, b);
        chk("eoi_inte", {24'd0, b}, 32'h04);
        rd(3'd3, v); chk("prio_claim3", v, 32'h8000_0003);
        rd(3'd4, v); chk("prio_count", v, 32'd2);

        // No new request while waiting for EOI.
        do_reset();
        wr(3'd2, 32'h24); wr(3'd1, 32'h24);
        src = 8'h04;
        trace(6, 8'h00, b);
        chk("wait_first", {24'd0, b}, 32'h04);
        src = 8'h20;
        trace(8, 8'h00, b);
        chk("wait_quiet", {24'd0, b}, 32'd0);
        rd(3'd0, v); chk("wait_pend", v, 32'h24);
        sel = 1'b1; wren = 1'b1; address = 3'd3; data = 32'd2;
        trace(6, 8'h00, b);
        chk("wait_eoi", {24'd0, b}, 32'h04);
        rd(3'd3, v); chk("wait_claim", v, 32'h8000_0005);

        // Set beats a same-cycle W1C; a plain W1C then clears.
        do_reset();
        wr(3'd2, 32'h01);
        src = 8'h01;
        wr(3'd0, 32'h01);
        rd(3'd0, v); chk("set_wins", v, 32'h01);
        wr(3'd0, 32'h01);
        rd(3'd0, v); chk("w1c_clear", v, 32'd0);
        src = 8'h00;

        // Counter saturation and EOI with out-of-range index.
        do_reset();
        wr(3'd1, 32'h01);
        for (int r = 0; r < 5; r++) begin
            src = 8'h01;
            cyc();
            src = 8'h00;
            repeat (3) cyc();
            wr(3'd3, 32'd0);
        end
        rd(3'd4, v); chk("count_sat", v, CMAX);
        wr(3'd4, 32'hDEAD_BEEF);
        rd(3'd4, v); chk("count_clr", v, 32'd0);
        src = 8'h01;
        cyc();
        src = 8'h00;
        repeat (3) cyc();
        wr(3'd3, 32'd9);
        rd(3'd0, v); chk("eoi_oob_pend", v, 32'h01);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 299) == 0);
            sel     = ($urandom_range(0, 3) != 0);
            wren    = ($urandom_range(0, 2) == 0);
            address = 3'($urandom_range(0, 7));
            data    = $urandom;
            src     = 8'($urandom & $urandom & $urandom);
            cyc();
        end
        reset = 1'b0; sel = 1'b0; wren = 1'b0; src = 8'h00;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/intc_mmio.md
# intc_mmio

Memory-mapped interrupt controller that is the responder side of the CPU's interrupt request line. It collects up to NSRC interrupt sources, latches them into a pending register, and applies a mask. It raises `inte` toward the `mips` core as a one-cycle request, then holds off until software acknowledges with an end-of-interrupt (EOI) write. It sits on the data-memory port beside `dcache`, uses the same word-addressed, one-cycle-latency read/write protocol, and is selected by the address decoder through `sel`.

## Interface
- NSRC, 8: number of interrupt sources, 1..31.
- CNT_W, 16: width of the saturating interrupt counter.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  block select from the data-port address decoder.
- address  in  3  word offset within the block (CPU byte address bits [4:2]).
- wren  in  1  write enable; effective only when `sel` is 1.
- data  in  32  write data.
- q  out  32  registered read data; reset value 0.
- src  in  NSRC  interrupt sources, synchronous to `clk`.
- inte  out  1  interrupt request pulse to the CPU; reset value 0.

## Operation
- Register map, selected by `address`:
  - 0 PEND: read returns pending bits. A write clears every bit written as 1 (W1C).
  - 1 MASK: read/write. A 1 enables the source. Reset value 0.
  - 2 EDGE: read/write. A 1 selects rising-edge detect for that source; a 0 selects level. Reset value 0.
  - 3 CLAIM: read returns {valid, 26'b0, index[4:0]}.
    - `index` is the lowest-numbered set bit of PEND&MASK.
    - `valid` = |(PEND&MASK); when `valid` is 0, `index` reads 0.
    - A write is an EOI: it clears PEND[data[4:0]] and returns the FSM to IDLE.
  - 4 COUNT: read returns the number of `inte` pulses, saturating at 2^CNT_W−1. A write of any value clears it to 0.
  - 5–7: reads return 0; writes are ignored.
- Bits above NSRC read 0 in PEND, MASK and EDGE, and writes to them are ignored.
- Reads have no side effects.
- Pending set rule, per source i:
  - Edge mode (EDGE[i]=1): PEND[i] is set when src[i]=1 and the registered previous src[i]=0.
  - Level mode: PEND[i] is set whenever src[i]=1, so it re-sets after a clear while the source stays high.
- When a set condition and a W1C/EOI clear of the same bit occur in one cycle, the set wins.
- An EOI index ≥ NSRC clears no bit but still returns the FSM to IDLE.
- FSM states are IDLE, REQ and WAIT.
  - IDLE → REQ when |(PEND&MASK) is 1.
  - REQ → WAIT unconditionally. `inte`=1 only in REQ, and COUNT increments on REQ entry.
  - WAIT → IDLE on an EOI write, or when PEND&MASK becomes 0 (e.g. by W1C or masking).
  - Sources arriving while in WAIT only set PEND; no new request is issued until the FSM is back in IDLE.
- Reset:
  - Clears PEND, MASK, EDGE, COUNT, the previous-src register and `q`.
  - Sets the FSM to IDLE and `inte` to 0.
  - Applies mid-request too: if reset is high while the FSM is in REQ, `inte` is 0 on the next cycle.

## Timing
- A write with `sel`=1 and `wren`=1 in cycle N takes effect at the edge ending cycle N, and its value is visible to reads issued in cycle N+1.
- A read issued in cycle N (`sel`=1, `wren`=0) is valid on `q` in cycle N+1. `q` holds its value while `sel`=0 or `wren`=1.
- A read in the same cycle as a write to the same register returns the old value.
- src rising edge at edge E sets PEND at edge E+1, the FSM enters REQ at E+2, and `inte` is high for exactly the cycle after E+2. Latency from src to `inte` is 2 cycles.
- After an EOI in cycle N, if another masked-pending source remains, `inte` pulses again at cycle N+2: the FSM is in IDLE at N+1 and in REQ at N+2.

## Test plan
- Reset: drive `reset`=1 for 2 cycles with src=8'hFF → q=0, inte=0, and PEND reads 0 after reset is released and MASK=0.
- Edge source: set EDGE=8'h04 and MASK=8'h04, pulse src[2] for 1 cycle → `inte` is high for exactly 1 cycle, 2 cycles after the edge; CLAIM reads 32'h8000_0002; COUNT reads 1.
- Priority and EOI: set MASK=8'h0A, assert level src[1] and src[3] → CLAIM reads index 1. After EOI 1, CLAIM reads index 3 and `inte` pulses again 2 cycles after the EOI; COUNT reads 2.
- No re-request in WAIT: after the first `inte`, toggle src[5] (edge mode, masked) → PEND[5] is set but `inte` stays 0 until an EOI write.
- Set-beats-clear: write PEND with W1C 8'h01 in the same cycle as a src[0] rising edge (edge mode) → PEND[0] reads 1.
- Saturation and unmapped offsets: with CNT_W=2, generate 5 requests → COUNT reads 3. A read of offset 6 returns 0, and a write to offset 6 changes no register.
